// File: rtl/nand_cpu_pkg.sv
// Shared branch-predictor types: table entry layout, counter constants
// and the saturating counter update used by the table write path.
package nand_cpu_pkg;

    localparam int BPU_PC_W    = 16;
    localparam int BPU_ENTRIES = 16;
    localparam int BPU_CTR_W   = 2;
    localparam int BPU_GHR_W   = 4;
    localparam int BPU_IDX_W   = $clog2(BPU_ENTRIES);
    localparam int BPU_TAG_W   = BPU_PC_W - BPU_IDX_W;

    localparam logic [BPU_CTR_W-1:0] CTR_WEAK_T  =
        {1'b1, {(BPU_CTR_W-1){1'b0}}};
    localparam logic [BPU_CTR_W-1:0] CTR_WEAK_NT =
        {1'b0, {(BPU_CTR_W-1){1'b1}}};
    localparam logic [BPU_CTR_W-1:0] CTR_ONE     =
        {{(BPU_CTR_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic                 valid;
        logic [BPU_TAG_W-1:0] tag;
        logic [BPU_PC_W-1:0]  target;
        logic                 is_jump;
        logic [BPU_CTR_W-1:0] ctr;
    } bpu_entry_t;

    // Counts toward taken/not-taken, sticking at both ends.
    function automatic logic [BPU_CTR_W-1:0] sat_update(
        input logic [BPU_CTR_W-1:0] ctr,
        input logic                 taken
    );
        logic [BPU_CTR_W-1:0] res;
        res = ctr;
        if (taken) begin
            if (!(&ctr)) res = ctr + CTR_ONE;
        end else begin
            if (|ctr) res = ctr - CTR_ONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/bpu_table.sv
// Branch target table storage: two combinational read ports (fetch
// lookup, resolve tag check) and one synchronous write port.
// Ports: clk, n_rst, rd_idx/rd_entry, rs_idx/rs_entry, wr_en/wr_idx/wr_entry.
module bpu_table
    import nand_cpu_pkg::*;
#(
    parameter int ENTRIES = BPU_ENTRIES
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx,
    output bpu_entry_t                 rd_entry,
    input  logic [$clog2(ENTRIES)-1:0] rs_idx,
    output bpu_entry_t                 rs_entry,
    input  logic                       wr_en,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  bpu_entry_t                 wr_entry
);

    bpu_entry_t mem [ENTRIES];

    assign rd_entry = mem[rd_idx];
    assign rs_entry = mem[rs_idx];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i].valid   <= 1'b0;
                mem[i].tag     <= '0;
                mem[i].target  <= '0;
                mem[i].is_jump <= 1'b0;
                mem[i].ctr     <= CTR_WEAK_NT;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// Predict-then-resolve branch control: tagged target table lookup for
// fetch, table update and registered flush/redirect from execute.
// Ports: f_* lookup in, p_* prediction out, r_* resolve in,
// flush/redirect_pc out. Optional gshare indexing: BPU_GSHARE_EN.
module branch_predictor_unit
    import nand_cpu_pkg::*;
#(
    parameter int PC_W    = BPU_PC_W,
    parameter int ENTRIES = BPU_ENTRIES,
    parameter int CTR_W   = BPU_CTR_W,
    parameter int GHR_W   = BPU_GHR_W
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       f_valid,
    input  logic [PC_W-1:0]            f_pc,
    output logic                       p_taken,
    output logic [PC_W-1:0]            p_target,
    output logic [$clog2(ENTRIES)-1:0] p_idx,
    input  logic                       r_valid,
    input  logic                       r_branch,
    input  logic                       r_jump,
    input  logic                       r_taken,
    input  logic [PC_W-1:0]            r_pc,
    input  logic [PC_W-1:0]            r_target,
    input  logic                       r_pred_taken,
    input  logic [PC_W-1:0]            r_pred_target,
    input  logic [$clog2(ENTRIES)-1:0] r_idx,
    output logic                       flush,
    output logic [PC_W-1:0]            redirect_pc
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] l_idx;
    bpu_entry_t       l_ent;
    bpu_entry_t       r_ent;
    bpu_entry_t       w_ent;
    logic             w_en;
    logic             l_hit;
    logic             r_hit;
    logic             upd;
    logic             mispredict;

    assign upd = r_valid & (r_branch | r_jump);

`ifdef BPU_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    assign l_idx = f_pc[IDX_W-1:0] ^ IDX_W'(ghr);

    // History only tracks committed conditional branches.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ghr <= '0;
        end else if (r_valid && r_branch) begin
            ghr <= {ghr[GHR_W-2:0], r_taken};
        end
    end
`else
    assign l_idx = f_pc[IDX_W-1:0];
`endif

    bpu_table #(
        .ENTRIES (ENTRIES)
    ) u_table (
        .clk      (clk),
        .n_rst    (n_rst),
        .rd_idx   (l_idx),
        .rd_entry (l_ent),
        .rs_idx   (r_idx),
        .rs_entry (r_ent),
        .wr_en    (w_en),
        .wr_idx   (r_idx),
        .wr_entry (w_ent)
    );

    assign l_hit = f_valid & l_ent.valid &
                   (l_ent.tag == f_pc[PC_W-1:IDX_W]);
    assign p_taken  = l_hit & (l_ent.is_jump | l_ent.ctr[CTR_W-1]);
    assign p_target = p_taken ? l_ent.target : f_pc + PC_ONE;
    assign p_idx    = l_idx;

    assign r_hit = r_ent.valid & (r_ent.tag == r_pc[PC_W-1:IDX_W]);

    always_comb begin
        w_en  = 1'b0;
        w_ent = r_ent;
        if (upd) begin
            if (r_hit) begin
                w_en          = 1'b1;
                w_ent.target  = r_target;
                w_ent.is_jump = r_jump;
                if (r_branch) w_ent.ctr = sat_update(r_ent.ctr, r_taken);
            end else if (r_taken) begin
                // Not-taken misses are left out so they cannot evict.
                w_en          = 1'b1;
                w_ent.valid   = 1'b1;
                w_ent.tag     = r_pc[PC_W-1:IDX_W];
                w_ent.target  = r_target;
                w_ent.is_jump = r_jump;
                w_ent.ctr     = CTR_WEAK_T;
            end
        end
    end

    assign mispredict = upd & ((r_pred_taken != r_taken) |
                        (r_taken & (r_pred_target != r_target)));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= r_taken ? r_target : r_pc + PC_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed self-checking bench for branch_predictor_unit.
// Ports exercised: all lookup, resolve, flush and redirect signals.
module tb_branch_predictor_unit;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        f_valid;
    logic [15:0] f_pc;
    logic        p_taken;
    logic [15:0] p_target;
    logic [3:0]  p_idx;
    logic        r_valid;
    logic        r_branch;
    logic        r_jump;
    logic        r_taken;
    logic [15:0] r_pc;
    logic [15:0] r_target;
    logic        r_pred_taken;
    logic [15:0] r_pred_target;
    logic [3:0]  r_idx;
    logic        flush;
    logic [15:0] redirect_pc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor_unit dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .f_valid       (f_valid),
        .f_pc          (f_pc),
        .p_taken       (p_taken),
        .p_target      (p_target),
        .p_idx         (p_idx),
        .r_valid       (r_valid),
        .r_branch      (r_branch),
        .r_jump        (r_jump),
        .r_taken       (r_taken),
        .r_pc          (r_pc),
        .r_target      (r_target),
        .r_pred_taken  (r_pred_taken),
        .r_pred_target (r_pred_target),
        .r_idx         (r_idx),
        .flush         (flush),
        .redirect_pc   (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic res(input logic br, input logic jp, input logic tk,
                       input logic [15:0] pc, input logic [15:0] tgt,
                       input logic ptk, input logic [15:0] ptgt);
        r_valid       = 1'b1;
        r_branch      = br;
        r_jump        = jp;
        r_taken       = tk;
        r_pc          = pc;
        r_target      = tgt;
        r_pred_taken  = ptk;
        r_pred_target = ptgt;
        r_idx         = pc[3:0];
    endtask

    task automatic res_idle();
        r_valid  = 1'b0;
        r_branch = 1'b0;
        r_jump   = 1'b0;
        r_taken  = 1'b0;
    endtask

    task automatic lookup(input logic [15:0] pc);
        f_valid = 1'b1;
        f_pc    = pc;
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        f_valid = 1'b0;
        f_pc = '0;
        r_pc = '0;
        r_target = '0;
        r_pred_taken = 1'b0;
        r_pred_target = '0;
        r_idx = '0;
        res_idle();
        repeat (2) @(posedge clk);
        #3 n_rst = 1'b1;

        check("rst_flush", flush, 0);
        check("rst_redir", redirect_pc, 0);
        lookup(16'h0010);
        check("cold_taken", p_taken, 0);
        check("cold_target", p_target, 16'h0011);
        check("cold_idx", p_idx, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_flush", flush, 0);
        end

        // jump 0x10 -> 0x40, predicted not taken
        step();
        res(0, 1, 1, 16'h0010, 16'h0040, 0, 16'h0011);
        step();
        res_idle();
        check("jmp_flush", flush, 1);
        check("jmp_redir", redirect_pc, 16'h0040);
        step();
        check("jmp_flush_end", flush, 0);
        lookup(16'h0010);
        check("jmp_taken", p_taken, 1);
        check("jmp_target", p_target, 16'h0040);

        // branch 0x20 -> 0x80: T (alloc 10), T (11), T (11)
        res(1, 0, 1, 16'h0020, 16'h0080, 0, 16'h0021);
        step();
        res_idle();
        check("br1_flush", flush, 1);
        check("br1_redir", redirect_pc, 16'h0080);
        lookup(16'h0020);
        check("br1_taken", p_taken, 1);
        check("br1_target", p_target, 16'h0080);
        res(1, 0, 1, 16'h0020, 16'h0080, 1, 16'h0080);
        step();
        check("br2_flush", flush, 0);
        step();
        res_idle();
        check("br3_flush", flush, 0);
        lookup(16'h0020);
        check("br3_taken", p_taken, 1);

        // not taken twice back to back: 11 -> 10 -> 01
        res(1, 0, 0, 16'h0020, 16'h0080, 1, 16'h0080);
        step();
        check("br4_flush", flush, 1);
        check("br4_redir", redirect_pc, 16'h0021);
        lookup(16'h0020);
        check("br4_taken", p_taken, 1);
        step();
        res_idle();
        check("br5_flush", flush, 1);
        check("br5_redir", redirect_pc, 16'h0021);
        lookup(16'h0020);
        check("br5_taken", p_taken, 0);
        check("br5_target", p_target, 16'h0021);

        // resolve with neither branch nor jump is ignored
        step();
        res(0, 0, 1, 16'h0030, 16'h0090, 0, 16'h0031);
        step();
        res_idle();
        check("ign_flush", flush, 0);
        lookup(16'h0030);
        check("ign_taken", p_taken, 0);

        // aliasing on index 3
        res(0, 1, 1, 16'h0013, 16'h0050, 0, 16'h0014);
        step();
        check("al1_flush", flush, 1);
        res(0, 1, 1, 16'h0113, 16'h0060, 0, 16'h0114);
        step();
        res_idle();
        check("al2_flush", flush, 1);
        check("al2_redir", redirect_pc, 16'h0060);
        lookup(16'h0013);
        check("al_old_taken", p_taken, 0);
        check("al_old_target", p_target, 16'h0014);
        lookup(16'h0113);
        check("al_new_taken", p_taken, 1);
        check("al_new_target", p_target, 16'h0060);

        // PC wrap and f_valid low
        lookup(16'hFFFF);
        check("wrap_target", p_target, 16'h0000);
        check("wrap_idx", p_idx, 4'hF);
        f_valid = 1'b0;
        f_pc = 16'h0010;
        #1;
        check("nvalid_taken", p_taken, 0);
        check("nvalid_target", p_target, 16'h0011);

        // same-cycle lookup and allocate on index 5
        step();
        res(0, 1, 1, 16'h0005, 16'h0070, 0, 16'h0006);
        lookup(16'h0005);
        check("sim_old_taken", p_taken, 0);
        check("sim_old_target", p_target, 16'h0006);
        step();
        res_idle();
        check("sim_new_taken", p_taken, 1);
        check("sim_new_target", p_target, 16'h0070);

        // right direction, wrong target
        res(0, 1, 1, 16'h0010, 16'h0044, 1, 16'h0040);
        step();
        res_idle();
        check("tgt_flush", flush, 1);
        check("tgt_redir", redirect_pc, 16'h0044);

        // reset with a mispredict resolve in flight
        step();
        res(1, 0, 0, 16'h0020, 16'h0080, 1, 16'h0080);
        #2 n_rst = 1'b0;
        #1;
        check("mrst_flush", flush, 0);
        check("mrst_redir", redirect_pc, 0);
        step();
        check("mrst_flush2", flush, 0);
        res_idle();
        #2 n_rst = 1'b1;
        step();
        check("post_flush", flush, 0);
        lookup(16'h0010);
        check("post_t10", p_taken, 0);
        check("post_g10", p_target, 16'h0011);
        lookup(16'h0113);
        check("post_t113", p_taken, 0);
        lookup(16'h0005);
        check("post_t05", p_taken, 0);
        check("post_idx05", p_idx, 4'h5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
- Parametrised next-generation branch control for the pipelined core.
- Gives fetch a direction and target prediction from a tagged branch target table with saturating counters.
- Accepts resolved branch/jump outcomes from execute, updates the table, and issues a registered flush/redirect on misprediction.
- Replaces single-cycle "override when jump | (branch & ps)" logic with predict-then-resolve operation.

Parameters:
PC_W, 16, program counter width in bits
ENTRIES, 16, table depth; power of two, at least 2
CTR_W, 2, saturating counter width; taken when counter MSB = 1
GHR_W, 4, global history length; only used when BPU_GSHARE_EN is defined; must be ≤ log2(ENTRIES)

Ports:
clk  in  1  core clock
n_rst  in  1  asynchronous active-low reset
f_valid  in  1  fetch lookup request valid
f_pc  in  PC_W  fetch PC
p_taken  out  1  predicted taken (combinational from f_pc)
p_target  out  PC_W  predicted target; equals f_pc+1 when not taken
p_idx  out  log2(ENTRIES)  table index used; travels down the pipe with the instruction
r_valid  in  1  resolve valid (execute stage; instruction not squashed)
r_branch  in  1  resolved instruction is a conditional branch
r_jump  in  1  resolved instruction is an unconditional jump
r_taken  in  1  actual direction (jump, or branch with ps set)
r_pc  in  PC_W  PC of resolved instruction
r_target  in  PC_W  actual target (rt operand)
r_pred_taken  in  1  p_taken carried from fetch
r_pred_target  in  PC_W  p_target carried from fetch
r_idx  in  log2(ENTRIES)  p_idx carried from fetch
flush  out  1  one-cycle pulse: squash younger instructions
redirect_pc  out  PC_W  fetch PC to load when flush=1

Behaviour:
- Entry fields: valid, tag (PC_W-log2(ENTRIES) upper PC bits), target, is_jump, counter.
- Lookup (combinational):
  - Index = f_pc[IDX-1:0].
  - Hit = valid & tag match & f_valid.
  - p_taken = hit & (is_jump | ctr MSB).
  - p_target = p_taken ? entry.target : f_pc+1 (mod 2^PC_W; wrap at all-ones PC).
- Resolve (clocked, on r_valid & (r_branch | r_jump)); update uses r_idx:
  - Entry tag match: branch counter saturating inc when taken, dec when not (no wrap past 0 or max); target and is_jump rewritten.
  - Tag miss and r_taken: allocate/overwrite with valid=1, tag, target, is_jump=r_jump, counter = weakly taken (100..0).
  - Tag miss and not taken: no allocation.
- Mispredict = r_pred_taken != r_taken, or (r_taken & r_pred_target != r_target).
- On mispredict: next cycle flush=1 and redirect_pc = r_taken ? r_target : r_pc+1; otherwise flush=0.
- Latency: resolve to flush is exactly one cycle. Resolve to table visibility is the next cycle.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (no bypass).
- r_valid with neither r_branch nor r_jump: ignored entirely.
- Back-to-back mispredicts: each produces its own flush pulse. Execute guarantees at most one resolve per cycle.
- Reset (async, n_rst=0):
  - All valid=0, counters = weakly not-taken (01..1), GHR=0.
  - flush=0, redirect_pc=0.
  - Reset mid-resolve discards the update.

Optional Feature:
- BPU_GSHARE_EN defined:
  - Lookup index = f_pc[IDX-1:0] XOR (GHR zero-extended).
  - GHR shifts in r_taken at each resolved conditional branch (non-speculative).
  - On mispredict the GHR update still applies.
- Undefined: index = f_pc[IDX-1:0]; no GHR register exists.
- Update always uses r_idx, so the bench is identical in both builds.

Decomposition:
- nand_cpu package holds:
  - bpu_entry_t struct
  - counter constants CTR_WEAK_T / CTR_WEAK_NT
  - function sat_update(ctr, taken)
- One sub-module, bpu_table: the entry array with combinational read port and one synchronous write port.

Test Plan:
- Reset, lookup f_pc=0x0010 → p_taken=0, p_target=0x0011. Flush stays 0 for 3 cycles.
- Resolve jump at 0x0010 → 0x0040, pred not taken:
  - Next cycle flush=1, redirect_pc=0x0040.
  - Later lookup of 0x0010 → p_taken=1, p_target=0x0040.
- Branch at 0x0020 resolved taken ×3 then not-taken ×1:
  - Counter goes 10→11→11 (saturates), then 10.
  - p_taken stays 1; only the first resolve flushes, plus the not-taken one (redirect 0x0021).
- Aliasing: PC 0x0013 and 0x0113 (ENTRIES=16) → second allocation evicts first; lookup of 0x0013 misses.
- Simultaneous: lookup index 5 in the same cycle as allocate to index 5 → old (miss) result; hit on the following cycle.
- Assert n_rst mid-stream while a mispredict resolve is in flight → flush=0, table empty afterwards. With BPU_GSHARE_EN, GHR=0 and the index equals the PC bits.
